mem_arbiter: RTL and testbench



---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_arbiter_rr_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-subsystem types: bus opcodes, arbiter states and line geometry.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b11
  } opcode;

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_ARB       = 3'd1,
    S_ISSUE     = 3'd2,
    S_WFILL     = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_RELEASE   = 3'd5
  } arb_state;

  // Number of bus words that make up one cache line.
  function automatic int fill_count(input int cl_size_width, input int word_size);
    return cl_size_width / word_size;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin pick: first eligible index at or after ptr, wrapping around.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Scan from ptr upward; the first hit wins and masks later candidates.
  always_comb begin
    int j;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      j = (int'(ptr) + off) % NUM_REQ;
      if (!any && eligible[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single mem_ctrl cache-line port between requesters.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int WORD_SIZE     = 32,
  parameter int CL_SIZE_WIDTH = 512,
  parameter int ADDR_BITCOUNT = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [2*NUM_REQ-1:0]             req_op,
  input  logic [ADDR_BITCOUNT*NUM_REQ-1:0] req_addr,
  input  logic [WORD_SIZE*NUM_REQ-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]               req_grant,
  output logic [NUM_REQ-1:0]               req_wnext,
  output logic [NUM_REQ-1:0]               req_rvalid,
  output logic [NUM_REQ-1:0]               req_done,
  output logic [WORD_SIZE-1:0]             rdata,
  input  logic                             mc_ready,
  input  logic                             mc_tx_done,
  input  logic                             mc_rd_valid,
  input  logic [WORD_SIZE-1:0]             mc_rdata,
  output logic [1:0]                       mc_op,
  output logic [WORD_SIZE-1:0]             mc_wdata,
  output logic [ADDR_BITCOUNT-1:0]         mc_addr,
  output logic                             busy,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id
);

  localparam int FILL_COUNT = fill_count(CL_SIZE_WIDTH, WORD_SIZE);
  localparam int BEAT_W     = $clog2(FILL_COUNT) + 1;
  localparam int IDX_W      = $clog2(NUM_REQ);

  arb_state                 state, state_n;
  logic [IDX_W-1:0]         rr_ptr;
  logic [IDX_W-1:0]         win_idx;
  opcode                    win_op;
  logic [ADDR_BITCOUNT-1:0] win_addr;
  logic [BEAT_W-1:0]        beat;
  logic [NUM_REQ-1:0]       done_q;

  logic [1:0]               op_arr [NUM_REQ];
  logic [WORD_SIZE-1:0]     wd_arr [NUM_REQ];
  logic [ADDR_BITCOUNT-1:0] ad_arr [NUM_REQ];
  logic [NUM_REQ-1:0]       eligible;
  logic [NUM_REQ-1:0]       pick_oh;
  logic [IDX_W-1:0]         pick_idx;
  logic                     pick_any;
  logic [NUM_REQ-1:0]       win_oh;
  logic                     active;

  // Unpack the flat per-requester buses and flag requests with a real READ/WRITE op.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_arr[i]   = req_op[2*i +: 2];
      wd_arr[i]   = req_wdata[WORD_SIZE*i +: WORD_SIZE];
      ad_arr[i]   = req_addr[ADDR_BITCOUNT*i +: ADDR_BITCOUNT];
      eligible[i] = req_valid[i] && (op_arr[i] == READ || op_arr[i] == WRITE);
    end
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .onehot   (pick_oh),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  // Control state: FSM, round-robin pointer, winner, beat counter and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_INIT;
      rr_ptr  <= '0;
      win_idx <= '0;
      win_op  <= IDLE;
      beat    <= '0;
      done_q  <= '0;
    end else begin
      state  <= state_n;
      done_q <= '0;
      if (state == S_ARB && pick_any) begin
        win_idx <= pick_idx;
        win_op  <= opcode'(op_arr[pick_idx]);
      end
      if (state == S_ISSUE) beat <= '0;
      if (state == S_WFILL) beat <= beat + 1'b1;
      if (state == S_WAIT_DONE && mc_tx_done) begin
        done_q <= win_oh;
        rr_ptr <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

  // Winner's line address, captured alongside the grant; outputs gate it outside a transaction.
  always_ff @(posedge clk) begin
    if (state == S_ARB && pick_any) win_addr <= ad_arr[pick_idx];
  end

  // Next-state and port outputs; the winner's values are only exposed ISSUE..WAIT_DONE.
  always_comb begin
    state_n    = state;
    win_oh     = NUM_REQ'(1) << win_idx;
    active     = (state == S_ISSUE) || (state == S_WFILL) || (state == S_WAIT_DONE);
    mc_op      = IDLE;
    mc_addr    = '0;
    mc_wdata   = '0;
    req_grant  = '0;
    req_wnext  = '0;
    req_rvalid = '0;
    req_done   = done_q;
    rdata      = mc_rd_valid ? mc_rdata : '0;
    busy       = active || (state == S_RELEASE);
    grant_id   = '0;

    case (state)
      S_INIT:      if (mc_ready) state_n = S_ARB;
      S_ARB:       if (pick_any) state_n = S_ISSUE;
      S_ISSUE:     state_n = (win_op == WRITE) ? S_WFILL : S_WAIT_DONE;
      S_WFILL:     if (beat == BEAT_W'(FILL_COUNT - 1)) state_n = S_WAIT_DONE;
      S_WAIT_DONE: if (mc_tx_done) state_n = S_RELEASE;
      S_RELEASE:   state_n = S_ARB;
      default:     state_n = S_INIT;
    endcase

    if (active) begin
      mc_op     = win_op;
      mc_addr   = win_addr;
      mc_wdata  = wd_arr[win_idx];
      req_grant = win_oh;
      if (win_op == READ && mc_rd_valid) req_rvalid = win_oh;
    end
    if (state == S_WFILL) req_wnext = win_oh;
    if (busy) grant_id = win_idx;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a hand-driven mem_ctrl side.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [7:0]   req_op;
  logic [255:0] req_addr;
  logic [127:0] req_wdata;
  logic [3:0]   req_grant, req_wnext, req_rvalid, req_done;
  logic [31:0]  rdata;
  logic         mc_ready, mc_tx_done, mc_rd_valid;
  logic [31:0]  mc_rdata;
  logic [1:0]   mc_op;
  logic [31:0]  mc_wdata;
  logic [63:0]  mc_addr;
  logic         busy;
  logic [1:0]   grant_id;
  logic [31:0]  line [16];

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_grant  (req_grant),
    .req_wnext  (req_wnext),
    .req_rvalid (req_rvalid),
    .req_done   (req_done),
    .rdata      (rdata),
    .mc_ready   (mc_ready),
    .mc_tx_done (mc_tx_done),
    .mc_rd_valid(mc_rd_valid),
    .mc_rdata   (mc_rdata),
    .mc_op      (mc_op),
    .mc_wdata   (mc_wdata),
    .mc_addr    (mc_addr),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1; req_valid = '0; req_op = '0; req_addr = '0; req_wdata = '0;
    mc_ready = 1'b0; mc_tx_done = 1'b0; mc_rd_valid = 1'b0; mc_rdata = '0;
    tick(); tick();
    rst = 1'b0; mc_ready = 1'b1;
    tick();
  endtask

  // Short read transaction from ARB back to ARB; checks owner and done pulse.
  task automatic rr_txn(input int exp, input bit drop);
    tick();
    chk("rr_grant_id", grant_id, exp);
    chk("rr_grant", req_grant, 4'b0001 << exp);
    tick();
    mc_tx_done = 1'b1;
    tick();
    mc_tx_done = 1'b0;
    chk("rr_done", req_done, 4'b0001 << exp);
    if (drop) req_valid[exp] = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    rst = 1'b1; req_valid = '0; req_op = '0; req_addr = '0; req_wdata = '0;
    mc_ready = 1'b0; mc_tx_done = 1'b0; mc_rd_valid = 1'b0; mc_rdata = '0;
    tick(); tick();
    chk("rst_mc_op", mc_op, 2'b00);
    chk("rst_grant", req_grant, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", req_done, 4'b0000);

    // Startup: mc_ready low for 10 cycles with requester 0 pending
    rst = 1'b0; req_valid = 4'b0001; req_op = 8'b0000_0001;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("startup_grant", req_grant, 4'b0000);
      chk("startup_mc_op", mc_op, 2'b00);
    end
    mc_ready = 1'b1;
    tick();
    chk("startup_arb_grant", req_grant, 4'b0000);
    tick();
    chk("startup_grant_on", req_grant, 4'b0001);
    chk("startup_mc_op_read", mc_op, 2'b01);

    // Single write from requester 2, word k = k
    reset_dut();
    req_valid = 4'b0100; req_op = 8'b0011_0000;
    req_addr[128 +: 64] = 64'h1000; req_wdata[64 +: 32] = 32'd0;
    tick();
    chk("wr_issue_grant", req_grant, 4'b0100);
    chk("wr_issue_op", mc_op, 2'b11);
    chk("wr_issue_addr", mc_addr, 64'h1000);
    chk("wr_issue_id", grant_id, 2'd2);
    chk("wr_issue_busy", busy, 1'b1);
    chk("wr_issue_wnext", req_wnext, 4'b0000);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("wr_wnext", req_wnext, 4'b0100);
      line[k] = mc_wdata;
      req_wdata[64 +: 32] = 32'(k + 1);
    end
    tick();
    chk("wr_wait_wnext", req_wnext, 4'b0000);
    chk("wr_wait_op", mc_op, 2'b11);
    tick();
    mc_tx_done = 1'b1;
    #1;
    chk("wr_done_early", req_done, 4'b0000);
    tick();
    mc_tx_done = 1'b0; req_valid = 4'b0000;
    chk("wr_done", req_done, 4'b0100);
    chk("wr_release_op", mc_op, 2'b00);
    chk("wr_release_grant", req_grant, 4'b0000);
    chk("wr_release_busy", busy, 1'b1);
    tick();
    chk("wr_done_once", req_done, 4'b0000);
    chk("wr_arb_busy", busy, 1'b0);
    for (int k = 0; k < 16; k++) chk("wr_line_word", line[k], 32'(k));

    // Single read from requester 1
    req_valid = 4'b0010; req_op = 8'b0000_0100; req_addr[64 +: 64] = 64'h2000;
    tick();
    chk("rd_issue_grant", req_grant, 4'b0010);
    chk("rd_issue_op", mc_op, 2'b01);
    chk("rd_issue_addr", mc_addr, 64'h2000);
    tick();
    for (int k = 0; k < 16; k++) begin
      mc_rd_valid = 1'b1; mc_rdata = 32'hA0 + 32'(k); mc_tx_done = (k == 15);
      #1;
      chk("rd_rvalid", req_rvalid, 4'b0010);
      chk("rd_rdata", rdata, 32'hA0 + 32'(k));
      if (k < 15) chk("rd_no_done", req_done, 4'b0000);
      tick();
    end
    mc_rd_valid = 1'b0; mc_tx_done = 1'b0; req_valid = 4'b0000;
    #1;
    chk("rd_done", req_done, 4'b0010);
    chk("rd_rvalid_off", req_rvalid, 4'b0000);
    tick();

    // All four requesters at once from rr_ptr = 0; requester 0 re-requests
    reset_dut();
    req_valid = 4'b1111; req_op = 8'b0101_0101;
    rr_txn(0, 1'b0);
    rr_txn(1, 1'b1);
    rr_txn(2, 1'b1);
    rr_txn(3, 1'b1);
    rr_txn(0, 1'b1);

    // Requester 3 with reserved op 2'b10 is never granted
    req_valid = 4'b1000; req_op = 8'b1000_0000;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bad_op_grant", req_grant, 4'b0000);
      chk("bad_op_mc_op", mc_op, 2'b00);
      chk("bad_op_busy", busy, 1'b0);
    end
    req_valid = 4'b0000;

    // Reset during WFILL beat 7 from rr_ptr = 1
    req_valid = 4'b0001; req_op = 8'b0000_0011; req_wdata[31:0] = 32'h55;
    tick();
    chk("rstw_issue_op", mc_op, 2'b11);
    for (int k = 0; k < 8; k++) tick();
    chk("rstw_wnext", req_wnext, 4'b0001);
    rst = 1'b1;
    tick();
    rst = 1'b0; mc_ready = 1'b0;
    #1;
    chk("rstw_mc_op", mc_op, 2'b00);
    chk("rstw_mc_addr", mc_addr, 64'h0);
    chk("rstw_mc_wdata", mc_wdata, 32'h0);
    chk("rstw_grant", req_grant, 4'b0000);
    chk("rstw_wnext_off", req_wnext, 4'b0000);
    chk("rstw_rvalid", req_rvalid, 4'b0000);
    chk("rstw_done", req_done, 4'b0000);
    chk("rstw_rdata", rdata, 32'h0);
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_grant_id", grant_id, 2'd0);
    req_valid = 4'b1001; req_op = 8'b0100_0001; mc_ready = 1'b1;
    tick();
    chk("rstw_arb_grant", req_grant, 4'b0000);
    tick();
    chk("rstw_ptr_zero", grant_id, 2'd0);
    chk("rstw_ptr_grant", req_grant, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
